// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file and trap sequencer (RUN/WAIT/FLUSH) for the five-stage core.
// Optional feature macro: CSR_COUNTERS_EN adds 64-bit mcycle/minstret (read-only).
module csr_trap_ctrl #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EXE_CSRSel,
  input  logic [1:0]  EXE_CSR_type,
  input  logic [1:0]  EXE_sys_op,
  input  logic [11:0] EXE_CSR_addr,
  input  logic [31:0] csr_wdata,
  input  logic [31:0] EXE_pc,
  input  logic        exe_valid,
  input  logic        stall_in,
  input  logic        retire,
  input  logic        ext_irq,
  input  logic        timer_irq,
  output logic [31:0] csr_rdata,
  output logic        CSR_stall,
  output logic        CSR_reset,
  output logic [31:0] redirect_pc
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [1:0] CSR_RW   = 2'b01;
  localparam logic [1:0] CSR_RS   = 2'b10;
  localparam logic [1:0] CSR_RC   = 2'b11;
  localparam logic [1:0] SYS_WFI  = 2'b01;
  localparam logic [1:0] SYS_MRET = 2'b10;

  localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_FLUSH
  } state_e;

  state_e      state_q, state_d;
  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic        mie_mtie_q, mie_mtie_d;
  logic        mie_meie_q, mie_meie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] wfi_pc_q, wfi_pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic [31:0] mstatus_rd, mie_rd, mip_rd;
  logic [1:0]  pend;
  logic        pend_any;
  logic        csr_wr;
  logic [31:0] csr_new;
  logic        trap_take;
  logic [31:0] trap_epc;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, retire};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

  assign mstatus_rd = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
  assign mie_rd     = {20'd0, mie_meie_q, 3'd0, mie_mtie_q, 7'd0};
  assign mip_rd     = {20'd0, ext_irq, 3'd0, timer_irq, 7'd0};
  // pend[1] = external, pend[0] = timer; external wins the cause encoding
  assign pend       = {ext_irq & mie_meie_q, timer_irq & mie_mtie_q};
  assign pend_any   = |pend;

  always_comb begin
    case (EXE_CSR_addr)
      ADDR_MSTATUS: csr_rdata = mstatus_rd;
      ADDR_MIE:     csr_rdata = mie_rd;
      ADDR_MTVEC:   csr_rdata = mtvec_q;
      ADDR_MEPC:    csr_rdata = mepc_q;
      ADDR_MCAUSE:  csr_rdata = mcause_q;
      ADDR_MIP:     csr_rdata = mip_rd;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: csr_rdata = mcycle_q[31:0];
      12'hB80, 12'hC80: csr_rdata = mcycle_q[63:32];
      12'hB02, 12'hC02: csr_rdata = minstret_q[31:0];
      12'hB82, 12'hC82: csr_rdata = minstret_q[63:32];
`endif
      default:      csr_rdata = '0;
    endcase
  end

  always_comb begin
    case (EXE_CSR_type)
      CSR_RW:  csr_new = csr_wdata;
      CSR_RS:  csr_new = csr_rdata | csr_wdata;
      CSR_RC:  csr_new = csr_rdata & ~csr_wdata;
      default: csr_new = csr_rdata;
    endcase
  end

  assign csr_wr = EXE_CSRSel && (EXE_CSR_type != 2'b00) && !stall_in && (state_q == S_RUN);

  always_comb begin
    state_d        = state_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_mtie_d     = mie_mtie_q;
    mie_meie_d     = mie_meie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    wfi_pc_d       = wfi_pc_q;
    redirect_pc_d  = redirect_pc_q;
    trap_take      = 1'b0;
    trap_epc       = EXE_pc;

    if (csr_wr) begin
      case (EXE_CSR_addr)
        ADDR_MSTATUS: begin
          mstatus_mie_d  = csr_new[3];
          mstatus_mpie_d = csr_new[7];
        end
        ADDR_MIE: begin
          mie_mtie_d = csr_new[7];
          mie_meie_d = csr_new[11];
        end
        ADDR_MTVEC:  mtvec_d  = csr_new;
        ADDR_MEPC:   mepc_d   = {csr_new[31:2], 2'b00};
        ADDR_MCAUSE: mcause_d = csr_new;
        default: ;
      endcase
    end

    case (state_q)
      S_RUN: begin
        if (!stall_in) begin
          if (EXE_CSRSel) begin
            if (EXE_sys_op == SYS_MRET) begin
              mstatus_mie_d  = mstatus_mpie_q;
              mstatus_mpie_d = 1'b1;
              redirect_pc_d  = mepc_q;
              state_d        = S_FLUSH;
            end else if (EXE_sys_op == SYS_WFI) begin
              wfi_pc_d = EXE_pc + 32'd4;
              if (!pend_any) state_d = S_WAIT;
            end
          end else if (exe_valid && mstatus_mie_q && pend_any) begin
            trap_take = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!stall_in && pend_any) begin
          if (mstatus_mie_q) begin
            trap_take = 1'b1;
            trap_epc  = wfi_pc_q;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_RUN;
    endcase

    // Trap entry is applied last so it overrides any same-cycle CSR write.
    if (trap_take) begin
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      mepc_d         = {trap_epc[31:2], 2'b00};
      mcause_d       = pend[1] ? CAUSE_EXT : CAUSE_TIMER;
      redirect_pc_d  = {mtvec_q[31:2], 2'b00};
      state_d        = S_FLUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_RUN;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mie_meie_q     <= 1'b0;
      mtvec_q        <= MTVEC_RST;
      mepc_q         <= '0;
      mcause_q       <= '0;
      wfi_pc_q       <= '0;
      redirect_pc_q  <= '0;
    end else begin
      state_q        <= state_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_mtie_q     <= mie_mtie_d;
      mie_meie_q     <= mie_meie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      wfi_pc_q       <= wfi_pc_d;
      redirect_pc_q  <= redirect_pc_d;
    end
  end

  assign CSR_stall   = (state_q == S_WAIT);
  assign CSR_reset   = (state_q == S_FLUSH);
  assign redirect_pc = redirect_pc_q;

endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Machine-mode CSR file and trap sequencer for the five-stage core. It serves CSR instructions that sit in EXE and takes machine external and timer interrupts. It executes WFI and MRET. It is the source of the `CSR_stall` and `CSR_reset` controls that the ID/EXE pipeline register consumes. It also produces the PC redirect target used on trap entry and on MRET.

## Interface
Parameters:
- `MTVEC_RST`, default 32'h0000_0000, reset value of mtvec.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high reset.
- `EXE_CSRSel`  in  1  valid CSR/system instruction in EXE.
- `EXE_CSR_type`  in  2  00 none, 01 CSRRW, 10 CSRRS, 11 CSRRC.
- `EXE_sys_op`  in  2  00 none, 01 WFI, 10 MRET, 11 reserved (treated as none).
- `EXE_CSR_addr`  in  12  CSR address.
- `csr_wdata`  in  32  forwarded rs1 value or zero-extended zimm.
- `EXE_pc`  in  32  PC of the instruction in EXE.
- `exe_valid`  in  1  EXE holds a real, non-bubble instruction.
- `stall_in`  in  1  im_stall | dm_stall.
- `retire`  in  1  one instruction retires in WB this cycle.
- `ext_irq`  in  1  machine external interrupt level.
- `timer_irq`  in  1  machine timer interrupt level.
- `csr_rdata`  out  32  old value of the addressed CSR (combinational).
- `CSR_stall`  out  1  hold IF/ID and bubble EXE.
- `CSR_reset`  out  1  one-cycle flush of IF/ID and ID/EXE.
- `redirect_pc`  out  32  fetch target, valid while `CSR_reset`=1.

## Operation
- CSR map:
  - mstatus 0x300: MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; other bits read 0.
  - mie 0x304: MTIE[7] and MEIE[11] are writable.
  - mtvec 0x305: fully writable; the target is {mtvec[31:2],2'b00}.
  - mepc 0x341: bits [1:0] are forced to 0.
  - mcause 0x342: fully writable.
  - mip 0x344: read-only; MTIP[7]=`timer_irq`, MEIP[11]=`ext_irq`, taken live from the inputs.
  - Unmapped addresses read 0 and ignore writes.
- CSR write: the new value is wdata for RW, old|wdata for RS, and old&~wdata for RC. It commits at the edge when `EXE_CSRSel`=1, type≠00, `stall_in`=0 and state=RUN.
- Pending set: pend = mip & mie (bits 7 and 11).
- FSM states:
  - RUN:
    - Interrupt taken when mstatus.MIE=1, pend≠0, `exe_valid`=1, `EXE_CSRSel`=0 and `stall_in`=0. Actions: trap entry with mepc=`EXE_pc`, then go to FLUSH. The EXE instruction is squashed.
    - MRET (`EXE_CSRSel`=1, sys_op=10, `stall_in`=0): MIE←MPIE, MPIE←1, redirect←mepc, then go to FLUSH.
    - WFI (`EXE_CSRSel`=1, sys_op=01, `stall_in`=0): record wfi_pc=`EXE_pc`+4. If pend≠0, stay in RUN and treat WFI as a NOP. Otherwise go to WAIT.
  - WAIT:
    - `CSR_stall`=1 throughout.
    - When pend≠0 and mstatus.MIE=0, go to RUN.
    - When pend≠0, mstatus.MIE=1 and `stall_in`=0: trap entry with mepc=wfi_pc, then go to FLUSH.
  - FLUSH: `CSR_reset`=1 for exactly one cycle, then go to RUN. CSR ops and interrupts are ignored in this state.
- Trap entry:
  - MPIE←MIE, MIE←0.
  - mcause: 32'h8000_000B when `ext_irq` is pending; otherwise 32'h8000_0007. External has priority over timer.
  - redirect←{mtvec[31:2],2'b00}.
- Priority in RUN: an interrupt can only be taken when `EXE_CSRSel`=0, so it never coincides with a CSR op, WFI or MRET. A CSR op that clears MIE blocks any interrupt from the next cycle on.
- `stall_in`=1 freezes CSR writes and FSM transitions. Counters keep running.

## Timing
- Reset values:
  - All CSRs 0, except mtvec=`MTVEC_RST`.
  - Counters 0; wfi_pc 0.
  - State RUN.
  - `CSR_stall`=0, `CSR_reset`=0, `redirect_pc`=0.
- `csr_rdata` is valid in the same cycle as the address. Written values become readable on the next cycle.
- `CSR_stall`, `CSR_reset` and `redirect_pc` are registered and decoded from state:
  - `CSR_stall` rises one cycle after WFI is accepted.
  - `CSR_reset` is asserted in the cycle after the trap/MRET decision.
- Reset asserted in WAIT or FLUSH forces RUN on the next edge, with outputs at their reset values.
- Interrupt latency from pend≠0 (MIE=1, `exe_valid`=1, no stall) to `CSR_reset` is 1 cycle.

## Configuration
- `CSR_COUNTERS_EN`:
  - Defined: 64-bit mcycle (+1 every cycle) and minstret (+1 when `retire`).
  - Readable at 0xB00/0xB80, 0xB02/0xB82, and at the shadows 0xC00/0xC80, 0xC02/0xC82.
  - Writes to these addresses are ignored.
  - Undefined: no counter logic; these addresses read 0.

## Test plan
- Reset, then CSRRW 0x305 with 32'h0000_1003; the next cycle reads 32'h0000_1003. CSRRS 0x304 with 32'h800 then CSRRC 0x304 with 32'h800: mie reads 0x800, then 0.
- MIE=1, MEIE=1, `ext_irq`=1 with EXE_pc=32'h200:
  - next cycle `CSR_reset`=1 and `redirect_pc`=32'h1000;
  - mepc=32'h200, mcause=32'h8000_000B, mstatus=32'h1880.
- Both `ext_irq` and `timer_irq` high, with both enabled: mcause=32'h8000_000B. With only `timer_irq`: mcause=32'h8000_0007.
- WFI at 32'h100 with pend=0:
  - `CSR_stall`=1 from the next cycle;
  - `timer_irq` asserted 10 cycles later with MTIE=1, MIE=1 gives `CSR_reset` pulse and mepc=32'h104.
  - With MIE=0, `CSR_stall` falls and there is no flush.
- MRET with mepc=32'h300, MPIE=1: `redirect_pc`=32'h300, `CSR_reset` pulses for 1 cycle, MIE=1. With `stall_in`=1 held for 3 cycles, the action is delayed by 3 cycles.
- With `CSR_COUNTERS_EN` defined: after 100 cycles, mcycle reads 100 and minstret equals the count of `retire` pulses. Without the macro, 0xC00 reads 0.
